pwm_seq_ctrl: RTL and testbench

//   Parametrised, multi-channel PWM sequencer that advances one step per frame_end_i pulse.

---
 rtl/pwm_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
//   Multi-channel PWM sequencer. It advances one step on each frame_end_i strobe and
//   supports down, up, triangle (centre-aligned) and binary-code-modulation (BCM)
//   sequences. The mode and the per-channel duty are double-buffered. New values take
//   effect only when a period starts.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   enable_i        1 = run the sequence, 0 = idle
//   mode_i          00 down, 01 up, 10 triangle, 11 BCM (sampled at period start)
//   frame_end_i     one-cycle step strobe; holding it high advances every cycle
//   duty_i          channel c duty at [c*PWM_DEPTH +: PWM_DEPTH] (sampled at period start)
//   pwm_cnt_o       current count; in BCM mode, the plane index zero-extended
//   pwm_on_o        per-channel on decision for the current step (zero latency)
//   period_start_o  one-cycle pulse on the first step of each period
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | sequencer stopped, registers at reset values, outputs off
// ST_RUN  | sequencer stepping on frame_end_i, reloads at period end
module pwm_seq_ctrl #(
  parameter int PWM_DEPTH = 8,
  parameter int N_CH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [1:0]                mode_i,
  input  logic                      frame_end_i,
  input  logic [N_CH*PWM_DEPTH-1:0] duty_i,
  output logic [PWM_DEPTH-1:0]      pwm_cnt_o,
  output logic [N_CH-1:0]           pwm_on_o,
  output logic                      period_start_o
);

  localparam int PW = $clog2(PWM_DEPTH);

  localparam logic [1:0] M_DOWN = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_TRI  = 2'b10;
  localparam logic [1:0] M_BCM  = 2'b11;

  localparam logic [PWM_DEPTH-1:0] CNT_MAX    = '1;
  localparam logic [PWM_DEPTH-1:0] CNT_ZERO   = '0;
  localparam logic [PWM_DEPTH-1:0] CNT_ONE    = PWM_DEPTH'(1);
  // The top plane is held for 2^(D-1) frames, so its hold count starts at 2^(D-1)-1.
  localparam logic [PWM_DEPTH-1:0] HOLD_START = CNT_MAX >> 1;
  localparam logic [PW-1:0]        PLANE_TOP  = PW'(PWM_DEPTH - 1);
  localparam logic [PW-1:0]        PLANE_ZERO = '0;
  localparam logic [PW-1:0]        PLANE_ONE  = PW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [PWM_DEPTH-1:0]      r_cnt;
  logic                      r_dir_down;
  logic [PW-1:0]             r_plane;
  logic [PWM_DEPTH-1:0]      r_hold;
  logic [1:0]                r_mode_sh;
  logic [N_CH*PWM_DEPTH-1:0] r_duty_sh;
  logic                      r_period_start;

  logic                      w_period_end;
  logic                      w_load;
  logic [PWM_DEPTH-1:0]      w_start_cnt;
  logic [PWM_DEPTH-1:0]      w_hold_next;
  logic [PWM_DEPTH-1:0]      w_ch_duty;

  // The last step of the period in the mode currently active (shadowed).
  always_comb begin
    w_period_end = 1'b0;
    case (r_mode_sh)
      M_DOWN:  w_period_end = (r_cnt == CNT_ZERO);
      M_UP:    w_period_end = (r_cnt == CNT_MAX);
      M_TRI:   w_period_end = r_dir_down && (r_cnt == CNT_ONE);
      default: w_period_end = (r_plane == PLANE_ZERO) && (r_hold == CNT_ZERO);
    endcase
  end

  // A load happens on the IDLE->RUN edge or at a period end. A frame_end_i in the
  // IDLE->RUN cycle is not a step, because the IDLE term already covers that cycle.
  assign w_load = enable_i &&
                  ((r_state == ST_IDLE) ||
                   ((r_state == ST_RUN) && frame_end_i && w_period_end));

  // The start count follows the incoming mode, because the load switches to it.
  assign w_start_cnt = ((mode_i == M_UP) || (mode_i == M_TRI)) ? CNT_ZERO : CNT_MAX;

  // Hold count on entering plane p-1: 2^(p-1)-1. Only used when r_plane >= 1.
  assign w_hold_next = (CNT_ONE << (r_plane - PLANE_ONE)) - CNT_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_cnt          <= CNT_MAX;
      r_dir_down     <= 1'b0;
      r_plane        <= PLANE_TOP;
      r_hold         <= CNT_ZERO;
      r_mode_sh      <= M_DOWN;
      r_duty_sh      <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_load;
      if (!enable_i) begin
        // Dropping enable wins over a simultaneous frame_end_i.
        r_state    <= ST_IDLE;
        r_cnt      <= CNT_MAX;
        r_dir_down <= 1'b0;
        r_plane    <= PLANE_TOP;
        r_hold     <= CNT_ZERO;
        r_mode_sh  <= M_DOWN;
        r_duty_sh  <= '0;
      end else if (w_load) begin
        r_state    <= ST_RUN;
        r_mode_sh  <= mode_i;
        r_duty_sh  <= duty_i;
        r_cnt      <= w_start_cnt;
        r_dir_down <= 1'b0;
        r_plane    <= PLANE_TOP;
        r_hold     <= HOLD_START;
      end else if ((r_state == ST_RUN) && frame_end_i) begin
        case (r_mode_sh)
          M_DOWN: r_cnt <= r_cnt - CNT_ONE;
          M_UP:   r_cnt <= r_cnt + CNT_ONE;
          M_TRI: begin
            if (r_dir_down) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
              // MAX is shown only once: turn around straight to MAX-1.
              r_cnt      <= CNT_MAX - CNT_ONE;
              r_dir_down <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            if (r_hold != CNT_ZERO) begin
              r_hold <= r_hold - CNT_ONE;
            end else begin
              r_plane <= r_plane - PLANE_ONE;
              r_hold  <= w_hold_next;
            end
          end
        endcase
      end
    end
  end

  assign pwm_cnt_o      = (r_mode_sh == M_BCM) ? PWM_DEPTH'(r_plane) : r_cnt;
  assign period_start_o = r_period_start;

  always_comb begin
    pwm_on_o  = '0;
    w_ch_duty = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_ch_duty = r_duty_sh[c*PWM_DEPTH +: PWM_DEPTH];
      if (r_state == ST_RUN) begin
        if (r_mode_sh == M_BCM) begin
          pwm_on_o[c] = w_ch_duty[r_plane];
        end else begin
          pwm_on_o[c] = (w_ch_duty > r_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl
//   Three builds of pwm_seq_ctrl (D=4/4ch, D=3/2ch, D=2/1ch) share the control inputs
//   and are compared each cycle against a reference model. The model tracks only
//   "running, shadowed mode/duty, step index k within the period". It derives the count
//   and the on decision from k arithmetically.
module tb_pwm_seq_ctrl;

  localparam int DA = 4, NA = 4, WA = DA*NA;
  localparam int DB = 3, NB = 2, WB = DB*NB;
  localparam int DC = 2, NC = 1, WC = DC*NC;

  logic clk = 1'b0;
  logic rst, enable, frame_end;
  logic [1:0] mode;
  logic [WA-1:0] duty_a;
  logic [WB-1:0] duty_b;
  logic [WC-1:0] duty_c;
  logic [DA-1:0] cnt_a;
  logic [DB-1:0] cnt_b;
  logic [DC-1:0] cnt_c;
  logic [NA-1:0] on_a;
  logic [NB-1:0] on_b;
  logic [NC-1:0] on_c;
  logic ps_a, ps_b, ps_c;

  always #5 clk = ~clk;

  pwm_seq_ctrl #(.PWM_DEPTH(DA), .N_CH(NA)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .frame_end_i(frame_end),
    .duty_i(duty_a), .pwm_cnt_o(cnt_a), .pwm_on_o(on_a), .period_start_o(ps_a));
  pwm_seq_ctrl #(.PWM_DEPTH(DB), .N_CH(NB)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .frame_end_i(frame_end),
    .duty_i(duty_b), .pwm_cnt_o(cnt_b), .pwm_on_o(on_b), .period_start_o(ps_b));
  pwm_seq_ctrl #(.PWM_DEPTH(DC), .N_CH(NC)) dut_c (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .frame_end_i(frame_end),
    .duty_i(duty_c), .pwm_cnt_o(cnt_c), .pwm_on_o(on_c), .period_start_o(ps_c));

  int checks = 0;
  int errors = 0;

  int dbits [3] = '{DA, DB, DC};
  int nch   [3] = '{NA, NB, NC};
  int m_run [3];
  int m_mode[3];
  int m_k   [3];
  int m_ps  [3];
  int m_duty[3][4];

  // ---------------- reference model ----------------
  function automatic int plen(int d, int md);
    int mx = (1 << d) - 1;
    case (md)
      0, 1:    return mx + 1;
      2:       return 2 * mx;
      default: return mx;
    endcase
  endfunction

  // Count (or BCM plane) shown at step k of a period.
  function automatic int seq_val(int d, int md, int k);
    int mx = (1 << d) - 1;
    int rem = k;
    int res = 0;
    bit found = 0;
    case (md)
      0: res = mx - k;
      1: res = k;
      2: res = (k <= mx) ? k : 2 * mx - k;
      default: begin
        // Plane p is held for 2^p frames, from the top plane down.
        for (int p = d - 1; p >= 0; p--) begin
          if (!found) begin
            if (rem < (1 << p)) begin
              res = p;
              found = 1;
            end else begin
              rem -= (1 << p);
            end
          end
        end
      end
    endcase
    return res;
  endfunction

  function automatic int in_duty(int id, int c);
    case (id)
      0:       return int'(duty_a[c*DA +: DA]);
      1:       return int'(duty_b[c*DB +: DB]);
      default: return int'(duty_c[c*DC +: DC]);
    endcase
  endfunction

  task automatic model_load(input int id);
    m_mode[id] = int'(mode);
    for (int c = 0; c < nch[id]; c++) m_duty[id][c] = in_duty(id, c);
    m_k[id]  = 0;
    m_ps[id] = 1;
  endtask

  task automatic model_edge();
    for (int id = 0; id < 3; id++) begin
      if (rst || !enable) begin
        m_run[id] = 0;
        m_ps[id]  = 0;
      end else if (m_run[id] == 0) begin
        m_run[id] = 1;
        model_load(id);
      end else if (frame_end) begin
        m_k[id]++;
        if (m_k[id] == plen(dbits[id], m_mode[id])) model_load(id);
        else m_ps[id] = 0;
      end else begin
        m_ps[id] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_cnt(int id);
    if (m_run[id] == 0) return 32'((1 << dbits[id]) - 1);
    return 32'(seq_val(dbits[id], m_mode[id], m_k[id]));
  endfunction

  function automatic logic [31:0] exp_on(int id);
    logic [31:0] v = '0;
    int s;
    if (m_run[id] == 0) return '0;
    s = seq_val(dbits[id], m_mode[id], m_k[id]);
    for (int c = 0; c < nch[id]; c++) begin
      if (m_mode[id] == 3) v[c] = ((m_duty[id][c] >> s) & 1) == 1;
      else                 v[c] = m_duty[id][c] > s;
    end
    return v;
  endfunction

  function automatic logic exp_ps(int id);
    return m_ps[id] != 0;
  endfunction

  // ---------------- DUT observation ----------------
  function automatic logic [31:0] act_cnt(int id);
    case (id)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  function automatic logic [31:0] act_on(int id);
    case (id)
      0:       return 32'(on_a);
      1:       return 32'(on_b);
      default: return 32'(on_c);
    endcase
  endfunction

  function automatic logic act_ps(int id);
    case (id)
      0:       return ps_a;
      1:       return ps_b;
      default: return ps_c;
    endcase
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [1:0] md);
    enable = 1'b0;
    frame_end = 1'b0;
    tick();
    mode = md;
    enable = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame_end = 1'b0; mode = 2'b00;
    duty_a = '0; duty_b = '0; duty_c = '0;
    tick();
    tick();
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({act_cnt(id), act_on(id), act_ps(id)} !==
          {32'((1 << dbits[id]) - 1), 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset dut%0d: cnt/on/ps got %0d/%0h/%0b want %0d/0/0",
                 id, act_cnt(id), act_on(id), act_ps(id), (1 << dbits[id]) - 1);
      end
    end
    rst = 1'b0;
    frame_end = 1'b1;
    tick();
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
        errors++;
        $display("FAIL idle_frame dut%0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                 id, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
      end
    end
  endtask

  task automatic test_down_sweep();
    duty_a = WA'($urandom); duty_b = WB'($urandom); duty_c = WC'($urandom);
    restart(2'b00);
    checks++;
    if ({cnt_a, ps_a} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL down_start: cnt/ps got %0d/%0b want 15/1", cnt_a, ps_a);
    end
    frame_end = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      for (int id = 0; id < 3; id++) begin
        checks++;
        if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
          errors++;
          $display("FAIL down_sweep dut%0d step %0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                   id, i, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
        end
      end
      if (i == 16) begin
        checks++;
        if ({cnt_a, ps_a} !== {4'd15, 1'b1}) begin
          errors++;
          $display("FAIL down_wrap: cnt/ps got %0d/%0b want 15/1", cnt_a, ps_a);
        end
      end
    end
    frame_end = 1'b0;
  endtask

  // Counts on-frames of one channel over a whole period and compares against the
  // brightness rules: down/up/BCM give d, triangle gives 2d-1 (0 and MAX occur once).
  task automatic test_brightness();
    int on_cnt, len, c, d, want;
    logic [1:0] md;
    for (int trial = 0; trial < 12; trial++) begin
      md = 2'(trial % 4);
      c  = $urandom_range(0, NA - 1);
      d  = (trial < 4) ? 0 : $urandom_range(0, (1 << DA) - 1);
      duty_a = WA'($urandom); duty_b = WB'($urandom); duty_c = WC'($urandom);
      duty_a[c*DA +: DA] = DA'(d);
      if (trial == 6) duty_b[0 +: DB] = 3'd3;
      if (trial == 7) duty_b[0 +: DB] = 3'b101;
      restart(md);
      on_cnt = 0;
      len = plen(DA, int'(md));
      for (int s = 0; s < len; s++) begin
        if (on_a[c] === 1'b1) on_cnt++;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        for (int id = 0; id < 3; id++) begin
          checks++;
          if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
            errors++;
            $display("FAIL bright_seq dut%0d mode %0d step %0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                     id, md, s, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
          end
        end
      end
      want = (md == 2'b10) ? ((d == 0) ? 0 : 2 * d - 1) : d;
      checks++;
      if (on_cnt != want || ps_a !== 1'b1) begin
        errors++;
        $display("FAIL brightness mode %0d duty %0d: on frames %0d ps %0b want %0d ps 1",
                 md, d, on_cnt, ps_a, want);
      end
    end
  endtask

  task automatic test_midperiod_change();
    duty_a = '0; duty_b = '0; duty_c = '0;
    restart(2'b01);
    frame_end = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    duty_a = {4{4'd8}}; duty_b = {2{3'd4}}; duty_c = 2'd2;
    mode = 2'b00;
    for (int i = 5; i < 22; i++) begin
      tick();
      for (int id = 0; id < 3; id++) begin
        checks++;
        if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
          errors++;
          $display("FAIL mid_change dut%0d step %0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                   id, i, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
        end
      end
      if (i < 15) begin
        checks++;
        if ({cnt_a, on_a} !== {4'(i + 1), 4'h0}) begin
          errors++;
          $display("FAIL mid_hold step %0d: cnt/on got %0d/%0h want %0d/0", i, cnt_a, on_a, i + 1);
        end
      end else if (i == 15) begin
        checks++;
        if ({cnt_a, on_a, ps_a} !== {4'd15, 4'h0, 1'b1}) begin
          errors++;
          $display("FAIL mid_reload: cnt/on/ps got %0d/%0h/%0b want 15/0/1", cnt_a, on_a, ps_a);
        end
      end
    end
    frame_end = 1'b0;
  endtask

  task automatic test_enable_drop();
    duty_a = WA'($urandom) | 16'h8888; duty_b = WB'($urandom); duty_c = WC'($urandom);
    restart(2'($urandom));
    frame_end = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    tick();
    checks++;
    if ({cnt_a, on_a, ps_a} !== {4'd15, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL enable_drop: cnt/on/ps got %0d/%0h/%0b want 15/0/0", cnt_a, on_a, ps_a);
    end
    tick();
    mode = 2'b01;
    enable = 1'b1;
    tick();
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
        errors++;
        $display("FAIL re_enable dut%0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                 id, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
      end
    end
    checks++;
    if ({cnt_a, ps_a} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL re_enable_load: cnt/ps got %0d/%0b want 0/1", cnt_a, ps_a);
    end
    frame_end = 1'b0;
  endtask

  task automatic test_async_reset();
    duty_a = '1; duty_b = '1; duty_c = '1;
    restart(2'b10);
    frame_end = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({act_cnt(id), act_on(id), act_ps(id)} !==
          {32'((1 << dbits[id]) - 1), 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL async_reset dut%0d: cnt/on/ps got %0d/%0h/%0b want %0d/0/0",
                 id, act_cnt(id), act_on(id), act_ps(id), (1 << dbits[id]) - 1);
      end
    end
    tick();
    rst = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic test_back_to_back();
    duty_a = WA'($urandom); duty_b = WB'($urandom); duty_c = WC'($urandom);
    restart(2'b11);
    frame_end = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) mode = 2'b10;
      tick();
      for (int id = 0; id < 3; id++) begin
        checks++;
        if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
          errors++;
          $display("FAIL back_to_back dut%0d cycle %0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                   id, i, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
        end
      end
    end
    frame_end = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 49) != 0);
      frame_end = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        duty_a = WA'($urandom); duty_b = WB'($urandom); duty_c = WC'($urandom);
      end
      tick();
      for (int id = 0; id < 3; id++) begin
        checks++;
        if ({act_cnt(id), act_on(id), act_ps(id)} !== {exp_cnt(id), exp_on(id), exp_ps(id)}) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d: cnt/on/ps got %0d/%0h/%0b want %0d/%0h/%0b",
                   id, i, act_cnt(id), act_on(id), act_ps(id), exp_cnt(id), exp_on(id), exp_ps(id));
        end
      end
    end
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      m_run[id] = 0; m_mode[id] = 0; m_k[id] = 0; m_ps[id] = 0;
      for (int c = 0; c < 4; c++) m_duty[id][c] = 0;
    end
    test_reset();
    test_down_sweep();
    test_brightness();
    test_midperiod_change();
    test_enable_drop();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
